// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32 control sequencer: FETCH/DECODE/EXECUTE/MEM/WB
// with memory handshakes, retire counter and sticky halt status.
module multicycle_sequencer #(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 start,
    input  logic [6:0]           opcode,
    input  logic                 zero,
    input  logic                 imem_valid,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_sel,
    output logic                 reg_write_en,
    output logic                 busy,
    output logic                 halted,
    output logic                 illegal,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] instr_count
);

    localparam int WAIT_W =
        (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    localparam logic [1:0] SEL_PC4 = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_JAL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    state_e                 state_q, state_d;
    logic [6:0]             op_q, op_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   halted_q, halted_d;
    logic                   illegal_q, illegal_d;
    logic                   timeout_q, timeout_d;

    function automatic logic is_known(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LUI, OP_LOAD,
            OP_STORE, OP_BEQ, OP_JAL, OP_ECALL: is_known = 1'b1;
            default:                            is_known = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        wait_d       = wait_q;
        cnt_d        = cnt_q;
        halted_d     = halted_q;
        illegal_d    = illegal_q;
        timeout_d    = timeout_q;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = SEL_PC4;
        reg_write_en = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = S_HALT;
                    halted_d  = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (opcode == OP_ECALL) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (!is_known(opcode)) begin
                    state_d   = S_HALT;
                    halted_d  = 1'b1;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                case (op_q)
                    OP_LOAD, OP_STORE: begin
                        state_d = S_MEM;
                        wait_d  = '0;
                    end
                    OP_BEQ: begin
                        pc_write = 1'b1;
                        pc_sel   = zero ? SEL_BR : SEL_PC4;
                        state_d  = S_FETCH;
                        wait_d   = '0;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_q == OP_STORE);
                if (dmem_ready) begin
                    if (op_q == OP_STORE) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                        wait_d   = '0;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = S_HALT;
                    halted_d  = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                reg_write_en = 1'b1;
                pc_write     = 1'b1;
                pc_sel       = (op_q == OP_JAL) ? SEL_JAL : SEL_PC4;
                state_d      = S_FETCH;
                wait_d       = '0;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase

        // Retirement is defined by the PC update, nothing else.
        if (pc_write) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            wait_q    <= '0;
            cnt_q     <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            cnt_q     <= cnt_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign timeout     = timeout_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed plus randomized instruction stream against a per-instruction
// timeline model of the sequencer.
module tb_multicycle_sequencer;

    localparam int TO = 15;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    logic        clk;
    logic        arst_n;
    logic        start;
    logic [6:0]  opcode;
    logic        zero;
    logic        imem_valid;
    logic        dmem_ready;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_sel;
    logic        reg_write_en;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic        timeout;
    logic [31:0] instr_count;

    int vectors = 0;
    int miscompares = 0;

    logic        m_halted;
    logic        m_illegal;
    logic        m_timeout;
    logic [31:0] m_count;

    multicycle_sequencer #(
        .CNT_WIDTH   (32),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .start        (start),
        .opcode       (opcode),
        .zero         (zero),
        .imem_valid   (imem_valid),
        .dmem_ready   (dmem_ready),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_sel       (pc_sel),
        .reg_write_en (reg_write_en),
        .busy         (busy),
        .halted       (halted),
        .illegal      (illegal),
        .timeout      (timeout),
        .instr_count  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // {imem_req,dmem_req,dmem_we,ir_write,pc_write,pc_sel,reg_write_en,busy}
    function automatic logic [8:0] ctl(
        input logic ireq, input logic dreq, input logic we,
        input logic irw, input logic pcw, input logic [1:0] sel,
        input logic rwe, input logic bsy);
        return {ireq, dreq, we, irw, pcw, sel, rwe, bsy};
    endfunction

    function automatic logic supported(input logic [6:0] op);
        return op == OP_R || op == OP_I || op == OP_LUI ||
               op == OP_LOAD || op == OP_STORE || op == OP_BEQ ||
               op == OP_JAL || op == OP_ECALL;
    endfunction

    task automatic model_clear();
        m_halted  = 1'b0;
        m_illegal = 1'b0;
        m_timeout = 1'b0;
        m_count   = '0;
    endtask

    task automatic cycle(input logic st, input logic iv, input logic dr,
                         input logic z, input logic [6:0] op,
                         input logic rst, input logic [8:0] c,
                         input string tag);
        logic [43:0] obs;
        logic [43:0] exp_v;
        @(posedge clk);
        #1;
        start      = st;
        imem_valid = iv;
        dmem_ready = dr;
        zero       = z;
        opcode     = op;
        arst_n     = rst;
        @(negedge clk);
        obs = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_sel,
               reg_write_en, busy, halted, illegal, timeout, instr_count};
        exp_v = {c, m_halted, m_illegal, m_timeout, m_count};
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp_v);
            $error("miscompare at %s", tag);
        end
    endtask

    task automatic hard_reset();
        @(posedge clk);
        #1;
        arst_n = 1'b0;
        start  = 1'b0;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        model_clear();
    endtask

    task automatic idle_cycle(input logic st, input string tag);
        cycle(st, rb(), rb(), rb(), 7'($urandom), 1'b1, 9'b0, tag);
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, rb(), rb(), rb(), 7'($urandom), 1'b1, 9'b0, "halt");
        end
    endtask

    // One instruction from its first FETCH cycle. iw/dw: idle cycles
    // before valid/ready (>= TO means never). abort_k: MEM cycle on
    // which reset is asserted, 0 for none.
    task automatic run_instr(input logic [6:0] op, input int iw,
                             input int dw, input logic z,
                             input int abort_k);
        logic hit;
        logic st_op;
        logic [6:0] arch_op;
        arch_op = op;
        st_op = (op == OP_STORE);
        for (int k = 1; k <= TO; k++) begin
            hit = (k == iw + 1);
            cycle(rb(), hit, rb(), rb(), 7'($urandom), 1'b1,
                  ctl(1, 0, 0, hit, 0, 2'b00, 0, 1), "fetch");
            if (hit) break;
            if (k == TO) begin
                m_halted  = 1'b1;
                m_timeout = 1'b1;
                return;
            end
        end
        cycle(rb(), rb(), rb(), rb(), arch_op, 1'b1,
              ctl(0, 0, 0, 0, 0, 2'b00, 0, 1), "decode");
        if (op == OP_ECALL) begin
            m_halted = 1'b1;
            return;
        end
        if (!supported(op)) begin
            m_halted  = 1'b1;
            m_illegal = 1'b1;
            return;
        end
        if (op == OP_BEQ) begin
            cycle(rb(), rb(), rb(), z, arch_op, 1'b1,
                  ctl(0, 0, 0, 0, 1, {1'b0, z}, 0, 1), "beq_exec");
            m_count++;
            return;
        end
        cycle(rb(), rb(), rb(), rb(), arch_op, 1'b1,
              ctl(0, 0, 0, 0, 0, 2'b00, 0, 1), "execute");
        if (op == OP_LOAD || op == OP_STORE) begin
            for (int k = 1; k <= TO; k++) begin
                hit = (k == dw + 1) && (k != abort_k);
                cycle(rb(), rb(), hit, rb(), arch_op, k != abort_k,
                      ctl(0, 1, st_op, 0, st_op && hit, 2'b00, 0, 1),
                      "mem");
                if (k == abort_k) begin
                    model_clear();
                    return;
                end
                if (hit) begin
                    if (st_op) begin
                        m_count++;
                        return;
                    end
                    break;
                end
                if (k == TO) begin
                    m_halted  = 1'b1;
                    m_timeout = 1'b1;
                    return;
                end
            end
        end
        cycle(rb(), rb(), rb(), rb(), arch_op, 1'b1,
              ctl(0, 0, 0, 0, 1, (op == OP_JAL) ? 2'b10 : 2'b00, 1, 1),
              "wb");
        m_count++;
    endtask

    initial begin
        logic [6:0] ops [7];
        ops = '{OP_R, OP_I, OP_LUI, OP_LOAD, OP_STORE, OP_BEQ, OP_JAL};
        arst_n     = 1'b0;
        start      = 1'b0;
        opcode     = '0;
        zero       = 1'b0;
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;

        idle_cycle(1'b0, "reset_idle");
        idle_cycle(1'b1, "start");
        run_instr(OP_R, 0, 0, 1'b0, 0);
        run_instr(OP_BEQ, 0, 0, 1'b1, 0);
        run_instr(OP_BEQ, 1, 0, 1'b0, 0);
        run_instr(OP_LOAD, 0, 2, 1'b0, 0);
        run_instr(OP_STORE, 2, 0, 1'b0, 0);
        run_instr(OP_JAL, 0, 0, 1'b0, 0);
        run_instr(OP_LUI, 3, 0, 1'b0, 0);
        run_instr(OP_I, TO - 1, 0, 1'b0, 0);
        run_instr(OP_LOAD, 0, TO - 1, 1'b0, 0);
        run_instr(OP_STORE, 0, TO - 1, 1'b0, 0);

        repeat (40) begin
            run_instr(ops[$urandom_range(0, 6)], $urandom_range(0, 3),
                      $urandom_range(0, 3), rb(), 0);
        end

        run_instr(OP_ECALL, 0, 0, 1'b0, 0);
        halt_cycles(3);

        hard_reset();
        idle_cycle(1'b0, "reset_idle2");
        idle_cycle(1'b1, "start2");
        run_instr(OP_R, 0, 0, 1'b0, 0);
        run_instr(OP_STORE, 0, 5, 1'b0, 2);
        idle_cycle(1'b0, "post_mem_reset");
        idle_cycle(1'b1, "start3");
        run_instr(OP_JAL, 0, 0, 1'b0, 0);
        run_instr(7'h7F, 0, 0, 1'b0, 0);
        halt_cycles(3);

        hard_reset();
        idle_cycle(1'b1, "start4");
        run_instr(OP_R, TO, 0, 1'b0, 0);
        halt_cycles(2);

        hard_reset();
        idle_cycle(1'b1, "start5");
        run_instr(OP_STORE, 0, TO, 1'b0, 0);
        halt_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
